pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit. Successor to the fixed 32-bit PC register, which loaded D into Q every clock.
- Holds the fetch address and generates the next PC internally: sequential increment, PC-relative branch, absolute jump.
- Adds stall, halt/resume control, alignment checking and a redirect flush pulse.
- Sits between the control/branch logic and instruction memory in the fetch stage.

Parameters:
- WIDTH, 32, PC and address width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- INC, 4, sequential increment in bytes; power of two, 1..8.
- RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16. Used only with RAS_EN.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- STALL  in  1  hold PC this cycle; sequential advance only.
- HALT  in  1  request entry to HALTED state.
- BR_TAKEN  in  1  branch taken this cycle.
- BR_OFFSET  in  WIDTH  signed byte offset, relative to current Q.
- JMP  in  1  absolute jump this cycle.
- JMP_TARGET  in  WIDTH  absolute jump address.
- CALL  in  1  push return address (RAS_EN only).
- RET  in  1  pop return address into PC (RAS_EN only).
- Q  out  WIDTH  current PC (fetch address).
- Q_PLUS  out  WIDTH  combinational Q+INC, modulo 2^WIDTH.
- VALID  out  1  Q is a valid fetch address.
- FLUSH  out  1  one-cycle pulse after any redirect.
- MISALIGN  out  1  sticky flag: a misaligned target was loaded.

Behaviour:
- One clock domain; all state updates on the rising edge of CLK.
- Reset is synchronous and active-high. With RST=1 at an edge: Q=RESET_VECTOR, VALID=0, FLUSH=0, MISALIGN=0, state=BOOT, RAS empty.
- States:
  - BOOT: one cycle, Q held, VALID=0. Next state RUN unconditionally, unless RST.
  - RUN: VALID=1.
  - HALTED: VALID=0, Q frozen.
- Next-PC priority in RUN, highest first:
  1. JMP: Q<=JMP_TARGET.
  2. RET (RAS_EN only).
  3. BR_TAKEN: Q<=Q+BR_OFFSET, modulo 2^WIDTH, wraps silently.
  4. STALL: Q unchanged.
  5. Otherwise: Q<=Q+INC, wraps at all-ones to 0.
- A redirect (JMP, BR_TAKEN or RET) overrides STALL. Next cycle FLUSH=1; otherwise FLUSH=0.
- HALT in RUN:
  - Without a redirect: Q is held and state becomes HALTED.
  - With a redirect in the same cycle: the redirect completes first, then the state becomes HALTED.
- HALTED: only JMP exits. Q<=JMP_TARGET, FLUSH=1 next cycle, state RUN. BR_TAKEN, RET, CALL and STALL are ignored.
- MISALIGN: set when a loaded target has any of the low log2(INC) bits nonzero. The target is still loaded unmodified. Cleared only by RST.
- Q_PLUS is purely combinational from Q; zero latency.
- Redirect latency: one cycle. The new Q is visible the cycle after the request.
- Reset mid-operation: overrides every input and returns to BOOT in the same edge.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- Defined:
  - Circular return-address stack with RAS_DEPTH entries, plus a count register.
  - CALL in RUN pushes Q_PLUS. It may coincide with JMP or BR_TAKEN (call plus target), and the push still occurs.
  - Push when full overwrites the oldest entry; count saturates.
  - RET in RUN pops the top into Q, unless JMP is also asserted, in which case JMP wins and no pop occurs.
  - RET when empty loads RESET_VECTOR and sets MISALIGN.
  - CALL and RET together: push then pop, i.e. net Q<=Q_PLUS, count unchanged, FLUSH=1.
- Undefined: CALL and RET ports remain but are ignored. No stack storage is synthesised.

Test Plan:
- Reset and sequential advance: RST=1 for 2 cycles, RESET_VECTOR=0, INC=4 -> Q=0, VALID=0 for one BOOT cycle, then Q=0x0, 0x4, 0x8, 0xC on successive cycles with VALID=1.
- Stall versus branch: Q=0x10, STALL=1 for 3 cycles -> Q stays 0x10. Then STALL=1 with BR_TAKEN=1, BR_OFFSET=0xFFFFFFF8 -> Q=0x08 next cycle and FLUSH=1 for one cycle.
- Priority and wrap: Q=0xFFFFFFFC, no control -> Q=0x00000000. Then JMP=1, JMP_TARGET=0x100 together with BR_TAKEN=1 -> Q=0x100. Then JMP_TARGET=0x102 -> Q=0x102 and MISALIGN=1, which stays 1 until RST.
- Halt and resume: HALT=1 at Q=0x40 -> VALID=0, Q=0x40 held. BR_TAKEN pulses are ignored. JMP=1, JMP_TARGET=0x80 -> Q=0x80, VALID=1, FLUSH=1.
- RAS with PC_UNIT_RAS_EN and RAS_DEPTH=4:
  - CALL+JMP at Q=0x20 (target 0x200) -> Q=0x200. RET -> Q=0x24.
  - 5 CALLs then 5 RETs -> the 5th RET hits an empty stack, giving Q=RESET_VECTOR and MISALIGN=1.
- Reset mid-run: RST=1 while Q=0x300 and HALTED -> next cycle Q=RESET_VECTOR, VALID=0, MISALIGN=0, then RUN resumes from RESET_VECTOR.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with sequential, branch, jump and
// halt/resume control, alignment checking and a post-redirect flush pulse.
// Ports:
//   CLK, RST (sync, active-high)
//   STALL, HALT, BR_TAKEN, BR_OFFSET, JMP, JMP_TARGET, CALL, RET (control in)
//   Q (fetch PC), Q_PLUS (Q+INC), VALID, FLUSH, MISALIGN (status out)
// Optional return-address stack is enabled by defining PC_UNIT_RAS_EN.
// Without it, CALL and RET are ignored and no stack storage is built.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALL,
    input  logic             HALT,
    input  logic             BR_TAKEN,
    input  logic [WIDTH-1:0] BR_OFFSET,
    input  logic             JMP,
    input  logic [WIDTH-1:0] JMP_TARGET,
    input  logic             CALL,
    input  logic             RET,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_PLUS,
    output logic             VALID,
    output logic             FLUSH,
    output logic             MISALIGN
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALTED
    } state_e;

    localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
    // Low log2(INC) address bits must be zero for an aligned target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             mis_q, mis_d;

    logic             redir;
    logic [WIDTH-1:0] tgt;
    logic             push, pop;
    logic             ras_empty;
    logic [WIDTH-1:0] ras_top;

`ifdef PC_UNIT_RAS_EN
    localparam bit          RAS_ON = 1'b1;
    localparam int unsigned AW     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [AW:0] FULL   = (AW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    // sp_q points at the next free slot; the ring wraps so a push
    // into a full stack overwrites the oldest entry.
    logic [AW-1:0]    sp_q;
    logic [AW:0]      cnt_q;

    assign ras_empty = (cnt_q == '0);
    assign ras_top   = ras_mem[sp_q - 1'b1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + 1'b1;
            if (cnt_q != FULL) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (pop) begin
            sp_q  <= sp_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            ras_mem[sp_q] <= Q_PLUS;
        end
    end
`else
    localparam bit RAS_ON = 1'b0;

    logic unused_ras;
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign unused_ras = push ^ pop;
`endif

    assign Q        = pc_q;
    assign Q_PLUS   = pc_q + INC_W;
    assign VALID    = (state_q == S_RUN);
    assign FLUSH    = flush_q;
    assign MISALIGN = mis_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        mis_d   = mis_q;
        redir   = 1'b0;
        tgt     = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                push = RAS_ON && CALL;
                if (JMP) begin
                    redir = 1'b1;
                    tgt   = JMP_TARGET;
                end else if (RAS_ON && RET) begin
                    redir = 1'b1;
                    if (CALL) begin
                        // Push then pop cancels out on the stack.
                        push = 1'b0;
                        tgt  = Q_PLUS;
                    end else if (ras_empty) begin
                        tgt   = RESET_VECTOR;
                        mis_d = 1'b1;
                    end else begin
                        pop = 1'b1;
                        tgt = ras_top;
                    end
                end else if (BR_TAKEN) begin
                    redir = 1'b1;
                    tgt   = pc_q + BR_OFFSET;
                end
                if (redir) begin
                    pc_d = tgt;
                end else if (!HALT && !STALL) begin
                    pc_d = Q_PLUS;
                end
                if (HALT) begin
                    state_d = S_HALTED;
                end
                flush_d = redir;
            end
            S_HALTED: begin
                if (JMP) begin
                    redir   = 1'b1;
                    tgt     = JMP_TARGET;
                    pc_d    = JMP_TARGET;
                    flush_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        if (redir && |(tgt & ALIGN_MASK)) begin
            mis_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

endmodule
